booth_radix4_multiplier: RTL and testbench
==========================================

// Module: booth_radix4_multiplier
// PURPOSE
// - Sequential radix-4 Booth multiplier; successor to the shift-add Multiplier, retiring 2 multiplier bits per cycle.
// - Parametrised width; per-operation signed/unsigned mode; Busy status; abort-and-reload on Begin.
// - Drop-in for the ALU multiply path: same Begin/Done handshake, same operand/product naming.
// PARAMETERS
// - WIDTH  16  operand width in bits; must be even and >= 4; Product is 2*WIDTH bits
// PORTS
// - CLK           in   1        system clock, all state updates on rising edge
// - RST           in   1        synchronous active-high reset
// - Multiplicand  in   WIDTH    operand A, captured while Begin=1
// - Multiplier    in   WIDTH    operand B, captured while Begin=1
// - Signed        in   1        1 = two's-complement operands, 0 = unsigned; captured while Begin=1
// - Begin         in   1        level: 1 = load/hold operands, falling level (sampled 0) = start
// - Busy          out  1        1 while in CALC
// - Done          out  1        1 in DONE; Product valid while Done=1
// - Product       out  2*WIDTH  result; sign-correct for Signed=1, zero-correct for Signed=0
// BEHAVIOUR
// - Clock is CLK; reset is synchronous, active-high on RST.
// - Reset: state=IDLE, Busy=0, Done=0, Product=0, internal registers cleared; RST wins over every other input.
// - States: IDLE, LOAD, CALC, DONE.
//   IDLE: Begin=1 -> LOAD (operands captured). Begin=0 -> stay.
//   LOAD: every edge with Begin=1 recaptures operands and Signed; edge with Begin=0 -> CALC (edge E0).
//   CALC: one Booth digit per edge; ITER = WIDTH/2 + 1 digits; after digit ITER-1 -> DONE.
//   DONE: Done=1, Product holds; Begin=1 -> LOAD; Begin=0 -> stay.
// - Begin=1 sampled in CALC: abort, operands recaptured, -> LOAD; Done stays 0; no partial Product exposed.
// - Operand extension: both operands extended to WIDTH+2 bits, sign-extended if Signed=1, zero-extended if 0;
//   ITER digits cover all extended bits, so unsigned 0xFFFF..F is exact.
// - Digit i from bits (2i+1, 2i, 2i-1), bit -1 = 0; digit in {-2,-1,0,+1,+2} applied to multiplicand,
//   accumulator WIDTH+4 bits wide (no overflow for -2 * most-negative).
// - Latency (no early term): Done=1 exactly ITER edges after E0 (WIDTH=16: 9 edges).
// - Product register updated only on the DONE-entry edge; otherwise holds last value.
// - Busy=1 exactly in CALC; Busy and Done never both 1.
// CONFIGURATION
// - MULT_EARLY_TERM_EN defined: on each CALC edge, after applying current digit, if all remaining
//   digits are zero (remaining extended bits all equal to the bit just consumed) the same edge applies
//   the remaining 2-bit arithmetic shifts in one step and enters DONE. Minimum latency 1 edge after E0.
//   Product identical to non-early-terminating result.
// - MULT_EARLY_TERM_EN undefined: fixed latency of ITER edges for every operand pair; no detection logic.
// TESTING
// - WIDTH=16, Signed=1, 0x8000 * 0x8000 -> Product 0x4000_0000; Done after 9 edges (8 with MULT_EARLY_TERM_EN).
// - Signed=0, 0xFFFF * 0xFFFF -> Product 0xFFFE_0001; Signed=1 same operands -> 0x0000_0001.
// - Signed=1, 0xFFFF * 0x8000 -> 0x0000_8000; 0x0003 * 0x0005 -> 0x0000_000F, Done 2 edges after E0 with
//   MULT_EARLY_TERM_EN, 9 without; Multiplier=0 -> Product 0, 1 edge with macro.
// - Begin pulsed high mid-CALC (edge 4) with new 0x0007*0x0009 -> LOAD, no Done; restart -> 0x0000_003F.
// - RST high mid-CALC -> next edge IDLE, Busy=0, Done=0, Product=0; RST held with Begin=1 stays IDLE.
// - 5000 LFSR pairs (taps 0xD004), both modes, vs $signed/$unsigned reference -> 0 fails; report avg cycles.

Source files
------------

// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier with Begin/Done handshake and per-operation signed mode.
// Optional feature: define MULT_EARLY_TERM_EN to finish as soon as all remaining Booth digits are zero.
module booth_radix4_multiplier #(
   parameter int WIDTH = 16
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [WIDTH-1:0]   Multiplicand,
   input  logic [WIDTH-1:0]   Multiplier,
   input  logic               Signed,
   input  logic               Begin,
   output logic               Busy,
   output logic               Done,
   output logic [2*WIDTH-1:0] Product
);

   localparam int ITER = WIDTH / 2 + 1;
   localparam int AW   = WIDTH + 4;
   localparam int MW   = WIDTH + 2;
   localparam int PW   = AW + MW + 1;
   localparam int CW   = $clog2(ITER + 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_DONE} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [AW-1:0]      r_mc;
   logic [PW-1:0]      r_p;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_product;
   logic               r_busy;
   logic               r_done;

   logic [AW-1:0]      w_ext_mc;
   logic [MW-1:0]      w_ext_mp;
   logic [AW-1:0]      w_addend;
   logic [AW-1:0]      w_sum;
   logic [PW-1:0]      w_shift;
   logic [PW-1:0]      w_step;
   logic               w_last;

   assign w_ext_mc = Signed ? {{4{Multiplicand[WIDTH-1]}}, Multiplicand} : {4'b0000, Multiplicand};
   assign w_ext_mp = Signed ? {{2{Multiplier[WIDTH-1]}}, Multiplier} : {2'b00, Multiplier};

   // r_p = {accumulator, unconsumed multiplier bits, bit -1}; low three bits form the current digit
   always_comb begin
      w_addend = {AW{1'b0}};
      case (r_p[2:0])
         3'b001, 3'b010: w_addend = r_mc;
         3'b011:         w_addend = {r_mc[AW-2:0], 1'b0};
         3'b100:         w_addend = {AW{1'b0}} - {r_mc[AW-2:0], 1'b0};
         3'b101, 3'b110: w_addend = {AW{1'b0}} - r_mc;
         default:        w_addend = {AW{1'b0}};
      endcase
   end

   assign w_sum   = r_p[PW-1 -: AW] + w_addend;
   assign w_shift = $signed({w_sum, r_p[MW:0]}) >>> 2;

`ifdef MULT_EARLY_TERM_EN
   logic          w_early;
   logic [CW:0]   w_amt;
   logic [PW-1:0] w_jump;

   // Remaining digits are all zero when the unconsumed bits all match the new bit -1
   always_comb begin
      w_early = 1'b1;
      for (int j = 1; j <= MW; j++) begin
         w_early = w_early & ((j > WIDTH - 2 * int'(r_cnt)) | (w_shift[j] == w_shift[0]));
      end
   end

   assign w_amt  = {CW'(ITER - 1) - r_cnt, 1'b0};
   assign w_jump = $signed(w_shift) >>> w_amt;
   assign w_step = w_early ? w_jump : w_shift;
   assign w_last = w_early | (r_cnt == CW'(ITER - 1));
`else
   assign w_step = w_shift;
   assign w_last = (r_cnt == CW'(ITER - 1));
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (Begin) w_next = S_LOAD;
            else       w_next = S_IDLE;
         end
         S_LOAD: begin
            if (Begin) w_next = S_LOAD;
            else       w_next = S_CALC;
         end
         S_CALC: begin
            if (Begin)       w_next = S_LOAD;
            else if (w_last) w_next = S_DONE;
            else             w_next = S_CALC;
         end
         S_DONE: begin
            if (Begin) w_next = S_LOAD;
            else       w_next = S_DONE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Begin=1 recaptures in every state; Product only changes on the DONE-entry edge
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= S_IDLE;
         r_mc      <= {AW{1'b0}};
         r_p       <= {PW{1'b0}};
         r_cnt     <= {CW{1'b0}};
         r_product <= {(2*WIDTH){1'b0}};
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next == S_CALC);
         r_done  <= (w_next == S_DONE);
         if (Begin) begin
            r_mc  <= w_ext_mc;
            r_p   <= {{AW{1'b0}}, w_ext_mp, 1'b0};
            r_cnt <= {CW{1'b0}};
         end else if (r_state == S_CALC) begin
            r_p   <= w_step;
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
            if (w_last) begin
               r_product <= w_step[2*WIDTH:1];
            end
         end
      end
   end

   assign Busy    = r_busy;
   assign Done    = r_done;
   assign Product = r_product;

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Directed and LFSR-driven checks of booth_radix4_multiplier at WIDTH=16.
module tb_booth_radix4_multiplier;

   logic        CLK = 1'b0;
   logic        RST;
   logic [15:0] Multiplicand;
   logic [15:0] Multiplier;
   logic        Signed;
   logic        Begin;
   logic        Busy;
   logic        Done;
   logic [31:0] Product;

   int n_cmp = 0;
   int n_err = 0;
   int last_lat;
   longint lat_sum = 0;

`ifdef MULT_EARLY_TERM_EN
   localparam int L_8000 = 0;
   localparam int L_FULL = 0;
   localparam int L_35   = 2;
   localparam int L_ZERO = 1;
`else
   localparam int L_8000 = 9;
   localparam int L_FULL = 9;
   localparam int L_35   = 9;
   localparam int L_ZERO = 9;
`endif

   always #5 CLK = ~CLK;

   booth_radix4_multiplier #(.WIDTH(16)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .Multiplicand (Multiplicand),
      .Multiplier   (Multiplier),
      .Signed       (Signed),
      .Begin        (Begin),
      .Busy         (Busy),
      .Done         (Done),
      .Product      (Product)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic load(input logic [15:0] a, input logic [15:0] b, input logic s);
      Begin        = 1'b1;
      Multiplicand = a;
      Multiplier   = b;
      Signed       = s;
      tick();
   endtask

   // Called just after the start edge E0; counts edges until Done
   task automatic wait_done(input string tag, input logic [31:0] exp, input int exp_lat);
      last_lat = 0;
      while (!Done && last_lat < 40) begin
         tick();
         last_lat++;
      end
      lat_sum += last_lat;
      chk({tag, " done"}, {63'd0, Done}, 64'd1);
      chk({tag, " product"}, {32'd0, Product}, {32'd0, exp});
      if (exp_lat > 0) chk({tag, " latency"}, 64'(last_lat), 64'(exp_lat));
   endtask

   task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b, input logic s,
                      input logic [31:0] exp, input int exp_lat);
      load(a, b, s);
      Begin = 1'b0;
      tick();
      wait_done(tag, exp, exp_lat);
   endtask

   initial begin
      logic [15:0]        lf;
      logic [15:0]        a;
      logic [15:0]        b;
      logic signed [31:0] ref_s;
      logic [31:0]        ref_v;

      RST = 1'b1; Begin = 1'b0; Signed = 1'b0; Multiplicand = 16'h0000; Multiplier = 16'h0000;
      tick();
      tick();
      chk("reset busy", {63'd0, Busy}, 64'd0);
      chk("reset done", {63'd0, Done}, 64'd0);
      chk("reset product", {32'd0, Product}, 64'd0);
      RST = 1'b0;
      tick();
      chk("idle busy", {63'd0, Busy}, 64'd0);

      run("s8000x8000", 16'h8000, 16'h8000, 1'b1, 32'h4000_0000, L_8000);

      // New Begin in DONE goes to LOAD and keeps the old product visible
      load(16'hFFFF, 16'hFFFF, 1'b0);
      chk("reload done", {63'd0, Done}, 64'd0);
      chk("reload busy", {63'd0, Busy}, 64'd0);
      chk("reload hold", {32'd0, Product}, 64'h4000_0000);
      Begin = 1'b0;
      tick();
      chk("calc busy", {63'd0, Busy}, 64'd1);
      wait_done("uFFFFxFFFF", 32'hFFFE_0001, L_FULL);
      chk("done busy", {63'd0, Busy}, 64'd0);

      run("sFFFFxFFFF", 16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, L_FULL);
      run("sFFFFx8000", 16'hFFFF, 16'h8000, 1'b1, 32'h0000_8000, L_FULL);
      run("s3x5",       16'h0003, 16'h0005, 1'b1, 32'h0000_000F, L_35);
      run("s1234x0",    16'h1234, 16'h0000, 1'b1, 32'h0000_0000, L_ZERO);
      run("u8000x8000", 16'h8000, 16'h8000, 1'b0, 32'h4000_0000, L_FULL);
      run("s7FFFx8000", 16'h7FFF, 16'h8000, 1'b1, 32'hC000_8000, L_FULL);

      // Abort: Begin pulsed on the fourth CALC edge
      load(16'h1234, 16'h5678, 1'b1);
      Begin = 1'b0;
      tick();
      tick(); tick(); tick();
      chk("abort pre busy", {63'd0, Busy}, 64'd1);
      Multiplicand = 16'h0007; Multiplier = 16'h0009; Begin = 1'b1;
      tick();
      chk("abort busy", {63'd0, Busy}, 64'd0);
      chk("abort done", {63'd0, Done}, 64'd0);
      chk("abort hold", {32'd0, Product}, 64'hC000_8000);
      Begin = 1'b0;
      tick();
      wait_done("restart7x9", 32'h0000_003F, L_FULL);

      // Reset in the middle of CALC, then held with Begin=1
      load(16'h00FF, 16'h00FF, 1'b0);
      Begin = 1'b0;
      tick();
      tick(); tick();
      RST = 1'b1;
      tick();
      chk("rst busy", {63'd0, Busy}, 64'd0);
      chk("rst done", {63'd0, Done}, 64'd0);
      chk("rst product", {32'd0, Product}, 64'd0);
      Begin = 1'b1;
      tick(); tick();
      chk("rst+begin busy", {63'd0, Busy}, 64'd0);
      RST = 1'b0; Begin = 1'b0;
      tick(); tick();
      chk("rst idle busy", {63'd0, Busy}, 64'd0);
      chk("rst idle done", {63'd0, Done}, 64'd0);

      lat_sum = 0;
      lf = 16'hACE1;
      for (int i = 0; i < 5000; i++) begin
         lf = lf[0] ? ((lf >> 1) ^ 16'hD004) : (lf >> 1);
         a  = lf;
         lf = lf[0] ? ((lf >> 1) ^ 16'hD004) : (lf >> 1);
         b  = lf;
         if (i[0]) begin
            ref_s = $signed(a) * $signed(b);
            ref_v = ref_s;
         end else begin
            ref_v = {16'h0000, a} * {16'h0000, b};
         end
         run(i[0] ? "lfsr signed" : "lfsr unsigned", a, b, i[0], ref_v, L_FULL);
      end
      $display("average cycles per operation: %0.2f", real'(lat_sum) / 5000.0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
